// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligned word/half/byte loads with extension, word stores
// in one cycle, sub-word stores as a 2-cycle read-modify-write against a word-only memory.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        mem_wren,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  off_q, off_d;
  logic        half_q, half_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;

  logic        aligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        busy_c, wren_c;

  function automatic logic [1:0] byte_lane(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  function automatic logic half_lane(input logic off1);
    return BIG_ENDIAN ? ~off1 : off1;
  endfunction

  always_comb begin
    unique case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Load path: pick the lane(s) from the combinational memory read and extend.
  always_comb begin
    ld_byte = mem_data_out[{byte_lane(req_addr[1:0]), 3'b000} +: 8];
    ld_half = mem_data_out[{half_lane(req_addr[1]), 4'b0000} +: 16];
    unique case (req_size)
      2'b00:   ld_ext = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      default: ld_ext = mem_data_out;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (half_q) merged[{half_lane(off_q[1]), 4'b0000} +: 16] = wdata_q;
    else        merged[{byte_lane(off_q), 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    waddr_d     = waddr_q;
    off_d       = off_q;
    half_d      = half_q;
    wdata_d     = wdata_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    misalign_d  = 1'b0;
    busy_c      = 1'b0;
    wren_c      = 1'b0;
    mem_address = {req_addr[31:2], 2'b00};
    mem_data_in = req_wdata;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!aligned) begin
            misalign_d = 1'b1;
          end else if (!req_we) begin
            ld_valid_d = 1'b1;
            ld_data_d  = ld_ext;
          end else if (req_size == 2'b10) begin
            wren_c = 1'b1;
          end else begin
            // Sub-word store: capture the old word this cycle, write it back merged next.
            busy_c  = 1'b1;
            word_d  = mem_data_out;
            waddr_d = req_addr[31:2];
            off_d   = req_addr[1:0];
            half_d  = req_size[0];
            wdata_d = req_wdata[15:0];
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        mem_address = {waddr_q, 2'b00};
        mem_data_in = merged;
        wren_c      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must kill a write already in flight, not just the next one.
  assign mem_wren = wren_c & reset;
  assign busy     = busy_c & reset;
  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign misalign = misalign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      waddr_q    <= '0;
      off_q      <= '0;
      half_q     <= 1'b0;
      wdata_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      waddr_q    <= waddr_d;
      off_q      <= off_d;
      half_q     <= half_d;
      wdata_q    <= wdata_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (little-endian lanes): directed table, reset-in-MERGE,
// then random traffic against a byte-array reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, ld_valid, misalign, mem_wren;
  logic [31:0] ld_data, mem_address, mem_data_in, mem_data_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] dmem [0:255];
  logic [7:0]  refm [0:1023];

  always #5 clk = ~clk;

  mem_access_unit #(.BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .ld_valid(ld_valid), .ld_data(ld_data),
    .misalign(misalign), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  assign mem_data_out = dmem[mem_address[9:2]];
  always @(posedge clk) if (mem_wren) dmem[mem_address[9:2]] <= mem_data_in;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [0:14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic is_aligned(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd0) || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'd0);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr[9:2]) * 4;
    return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    int a;
    logic [31:0] v;
    a = int'(addr[9:0]);
    if (size == 2'd0) begin
      v = {24'h0, refm[a]};
      if (!uns && v[7]) v[31:8] = 24'hFFFFFF;
    end else if (size == 2'd1) begin
      v = {16'h0, refm[a+1], refm[a]};
      if (!uns && v[15]) v[31:16] = 16'hFFFF;
    end else begin
      v = ref_word(addr);
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    a = int'(addr[9:0]);
    refm[a] = wd[7:0];
    if (size != 2'd0) refm[a+1] = wd[15:8];
    if (size == 2'd2) begin
      refm[a+2] = wd[23:16];
      refm[a+3] = wd[31:24];
    end
  endtask

  // One request, held until consumed; exp is ld_data for loads or the merged word for SB/SH.
  task automatic run_req(input vec_t v);
    logic al, sub, sw;
    al  = is_aligned(v.size, v.addr);
    sub = al && v.we && v.size != 2'd2;
    sw  = al && v.we && v.size == 2'd2;
    if (al && v.we) ref_store(v.size, v.addr, v.wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    #1;
    check("busy_c0", busy, sub);
    check("wren_c0", mem_wren, sw);
    check("addr_c0", mem_address, {v.addr[31:2], 2'b00});
    if (sw) check("sw_data", mem_data_in, v.wdata);
    @(posedge clk); #1;
    if (sub) begin
      check("busy_merge", busy, 1'b0);
      check("wren_merge", mem_wren, 1'b1);
      check("addr_merge", mem_address, {v.addr[31:2], 2'b00});
      check("merge_data", mem_data_in, v.exp);
      @(posedge clk); #1;
    end
    check("ld_valid", ld_valid, al && !v.we);
    check("misalign", misalign, !al);
    if (al && !v.we) check("ld_data", ld_data, v.exp);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_wren", mem_wren, 1'b0);
    @(posedge clk); #1;
    check("idle_ldv", ld_valid, 1'b0);
    check("idle_mis", misalign, 1'b0);
  endtask

  initial begin
    vec_t v;
    int bad;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AA, 32'hDEADAAEF};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'hFFFFFFAA};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h000000AA};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001, 32'h8001AAEF};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hFFFF8001};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h00008001};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h103, 32'h0000BEEF, 32'h0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8001AAEF};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8001AAEF};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h00000011, 32'h1101AAEF};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1101AAEF};

    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) refm[i] = 8'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ldv", ld_valid, 1'b0);
    check("rst_ldd", ld_data, 32'h0);
    check("rst_mis", misalign, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i <= 11; i++) run_req(tbl[i]);

    // Reset lands in the MERGE cycle of SB 0x100 <- 0x55: the write must be lost.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h55;
    #1;
    check("rm_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("rm_wren_pre", mem_wren, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_wren", mem_wren, 1'b0);
    check("rm_busy0", busy, 1'b0);
    check("rm_ldv", ld_valid, 1'b0);
    check("rm_ldd", ld_data, 32'h0);
    check("rm_mis", misalign, 1'b0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("rm_word", dmem[32'h100 >> 2], 32'h8001AAEF);
    idle_cycle();

    for (int i = 12; i <= 14; i++) run_req(tbl[i]);

    for (int n = 0; n < 300; n++) begin
      v.we    = 1'($urandom_range(1));
      v.size  = 2'($urandom_range(3));
      v.uns   = 1'($urandom_range(1));
      v.addr  = 32'($urandom_range(1023));
      v.wdata = $urandom;
      v.exp   = 32'h0;
      if (is_aligned(v.size, v.addr)) begin
        if (!v.we) v.exp = ref_load(v.size, v.uns, v.addr);
        else if (v.size != 2'd2) begin
          ref_store(v.size, v.addr, v.wdata);
          v.exp = ref_word(v.addr);
          // run_req reapplies the same store; harmless but keep it single-sourced
          ref_store(v.size, v.addr, v.wdata);
        end
      end
      run_req(v);
      if ($urandom_range(3) == 0) idle_cycle();
    end
    idle_cycle();

    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_word(32'(i * 4))) bad++;
    check("mem_image_bad_words", 32'(bad), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
